// File: rtl/restoring_divider_4bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock through
// trial subtraction, with a start/busy/done handshake and divide-by-zero flag.
module restoring_divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted_r;
  logic             trial_ok;
  logic [WIDTH-1:0] trial_low;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;

  // The partial remainder is always below D, so only the shifted value needs
  // the extra bit; a successful trial result fits back into WIDTH bits.
  always_comb begin
    shifted_r = {r_q, q_q[WIDTH-1]};
    trial_ok  = (shifted_r >= {1'b0, d_q});
    trial_low = shifted_r[WIDTH-1:0] - d_q;
    r_d       = trial_ok ? trial_low : shifted_r[WIDTH-1:0];
    q_d       = {q_q[WIDTH-2:0], trial_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_q     <= ST_DONE;
            quotient_q  <= q_d;
            remainder_q <= r_d;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back issue.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (start) begin
            d_q     <= divisor;
            q_q     <= dividend;
            r_q     <= '0;
            count_q <= '0;
            if (divisor == '0) begin
              state_q     <= ST_DONE;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
